// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes
// and every datapath select value. The immediate extender uses IMM_* as well.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, UPPER
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:        return IMM_S;
      OP_BRANCH:       return IMM_B;
      OP_JAL:          return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:         return IMM_I;
    endcase
  endfunction

  function automatic logic is_supported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
      OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus the instruction funct fields onto
// the ALU's operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op_b5_i,
  output logic [2:0] alu_control_o
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALU_OP_SUB: alu_control_o = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3_i)
          // op[5] separates R-type sub from addi, whose imm[10] aliases funct7b5.
          3'b000:  alu_control_o = (op_b5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core: sequences fetch through
// writeback over the shared ALU and unified memory port.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_e RESET_STATE = FETCH
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       illegal_instr
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_LUI, OP_AUIPC:  state_d = UPPER;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JAL:      state_d = ALUWB;
      UPPER:    state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RD2;
    alu_op        = ALU_OP_ADD;
    case (state_q)
      FETCH: begin
        result_src   = RES_ALURESULT;
        alu_src_b    = SRCB_FOUR;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
      end
      DECODE: begin
        // ALU precomputes the branch/jump target from OldPC while decoding.
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_IMM;
        illegal_raw = ~is_supported(op);
      end
      MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALU_OP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      ALUWB:    reg_write_raw = 1'b1;
      BRANCH: begin
        alu_src_a    = SRCA_RD1;
        alu_op       = ALU_OP_SUB;
        pc_write_raw = (funct3[2:1] == 2'b00) & (zero ^ funct3[0]);
      end
      JAL: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        pc_write_raw = 1'b1;
      end
      UPPER: begin
        alu_src_a = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op_b5_i       (op[5]),
    .alu_control_o (alu_control)
  );

  assign imm_src = imm_src_of(op);

  // Reset suppresses all side effects even in the cycle it is first seen.
  assign pc_write      = pc_write_raw  & ~reset;
  assign ir_write      = ir_write_raw  & ~reset;
  assign mem_write     = mem_write_raw & ~reset;
  assign reg_write     = reg_write_raw & ~reset;
  assign illegal_instr = illegal_raw   & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed vector table, hand-built multi-cycle corner
// cases and randomized instruction streams against a per-instruction model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .imm_src       (imm_src),
    .reg_write     (reg_write),
    .illegal_instr (illegal_instr)
  );

  // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu_control, imm_src, reg_write, illegal}
  logic [17:0] act;
  assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_control, imm_src, reg_write, illegal_instr};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%05h want=%05h (pcw,adr,mw,irw,rs,a,b,alu,imm,rw,ill)",
               name, got, exp);
    end
  endtask

  function automatic logic [17:0] o(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                    input logic [1:0] b, input logic [2:0] alu,
                                    input logic [2:0] imm, input logic rw, input logic ill);
    return {pcw, adr, mw, irw, rs, a, b, alu, imm, rw, ill};
  endfunction

  // ---------------- reference model ----------------
  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_UPPER} ph_t;

  ph_t plan_q[$];

  function automatic logic legal(input logic [6:0] v);
    return v inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
  endfunction

  // Step list of one instruction, straight from the per-class latency rules.
  function automatic void build_plan(input logic [6:0] v);
    plan_q = {};
    plan_q.push_back(P_FETCH);
    plan_q.push_back(P_DECODE);
    case (v)
      7'b0000011: begin plan_q.push_back(P_MEMADR); plan_q.push_back(P_MEMREAD); plan_q.push_back(P_MEMWB); end
      7'b0100011: begin plan_q.push_back(P_MEMADR); plan_q.push_back(P_MEMWRITE); end
      7'b0110011: begin plan_q.push_back(P_EXECR); plan_q.push_back(P_ALUWB); end
      7'b0010011: begin plan_q.push_back(P_EXECI); plan_q.push_back(P_ALUWB); end
      7'b1100011: plan_q.push_back(P_BRANCH);
      7'b1101111: begin plan_q.push_back(P_JAL); plan_q.push_back(P_ALUWB); end
      7'b0110111, 7'b0010111: begin plan_q.push_back(P_UPPER); plan_q.push_back(P_ALUWB); end
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] model_imm(input logic [6:0] v);
    if (v == 7'b0100011) return 3'd1;
    if (v == 7'b1100011) return 3'd2;
    if (v == 7'b1101111) return 3'd3;
    if (v == 7'b0110111 || v == 7'b0010111) return 3'd4;
    return 3'd0;
  endfunction

  // ALU operation an instruction's funct fields ask for.
  function automatic logic [2:0] model_funct_alu(input logic [6:0] v, input logic [2:0] f3, input logic f7);
    if (f3 == 3'd0) return (v[5] && f7) ? 3'd1 : 3'd0;
    if (f3 == 3'd2) return 3'd5;
    if (f3 == 3'd6) return 3'd3;
    if (f3 == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [17:0] model_out(input ph_t ph, input logic [6:0] v, input logic [2:0] f3,
                                            input logic f7, input logic z, input logic mr,
                                            input logic rst);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, ill} = '0;
    rs = 2'd0; a = 2'd0; b = 2'd0; alu = 3'd0;
    case (ph)
      P_FETCH:    begin rs = 2'd2; b = 2'd2; pcw = mr; irw = mr; end
      P_DECODE:   begin a = 2'd1; b = 2'd1; ill = !legal(v); end
      P_MEMADR:   begin a = 2'd2; b = 2'd1; end
      P_MEMREAD:  adr = 1'b1;
      P_MEMWB:    begin rs = 2'd1; rw = 1'b1; end
      P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      P_EXECR:    begin a = 2'd2; alu = model_funct_alu(v, f3, f7); end
      P_EXECI:    begin a = 2'd2; b = 2'd1; alu = model_funct_alu(v, f3, f7); end
      P_ALUWB:    rw = 1'b1;
      P_BRANCH:   begin a = 2'd2; alu = 3'd1; pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0; end
      P_JAL:      begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
      P_UPPER:    begin b = 2'd1; a = v[5] ? 2'd3 : 2'd1; end
      default: ;
    endcase
    if (rst) {pcw, mw, irw, rw, ill} = '0;
    return o(pcw, adr, mw, irw, rs, a, b, alu, model_imm(v), rw, ill);
  endfunction

  // One clock: apply inputs, compare at the falling edge, then advance.
  task automatic cyc(input string name, input ph_t ph, input logic mr, input logic rst);
    mem_ready = mr;
    reset     = rst;
    @(negedge clk);
    check(name, act, model_out(ph, op, funct3, funct7b5, zero, mr, rst));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] v, input logic [2:0] f3,
                           input logic f7, input logic z, input int fetch_wait, input int mem_wait);
    op = v; funct3 = f3; funct7b5 = f7; zero = z;
    build_plan(v);
    foreach (plan_q[i]) begin
      ph_t ph = plan_q[i];
      if (ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWRITE) begin
        int w = (ph == P_FETCH) ? fetch_wait : mem_wait;
        for (int k = 0; k < w; k++) cyc($sformatf("%s.%s.wait%0d", tag, ph.name(), k), ph, 1'b0, 1'b0);
        cyc($sformatf("%s.%s", tag, ph.name()), ph, 1'b1, 1'b0);
      end else begin
        cyc($sformatf("%s.%s", tag, ph.name()), ph, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        mr;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); #1;

    // reset held: FETCH outputs with write enables suppressed
    vecs.push_back('{1'b1, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, o(0,0,0,0,2'd2,2'd0,2'd2,3'd0,3'd0,0,0)});
    // add x3,x1,x2
    vecs.push_back('{1'b0, 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b1, o(1,0,0,1,2'd2,2'd0,2'd2,3'd0,3'd0,0,0)});
    vecs.push_back('{1'b0, 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b1, o(0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0,0)});
    vecs.push_back('{1'b0, 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b1, o(0,0,0,0,2'd0,2'd2,2'd0,3'd0,3'd0,0,0)});
    vecs.push_back('{1'b0, 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b1, o(0,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,1,0)});
    // sub
    vecs.push_back('{1'b0, 7'b0110011, 3'd0, 1'b1, 1'b0, 1'b1, o(1,0,0,1,2'd2,2'd0,2'd2,3'd0,3'd0,0,0)});
    vecs.push_back('{1'b0, 7'b0110011, 3'd0, 1'b1, 1'b0, 1'b1, o(0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0,0)});
    vecs.push_back('{1'b0, 7'b0110011, 3'd0, 1'b1, 1'b0, 1'b1, o(0,0,0,0,2'd0,2'd2,2'd0,3'd1,3'd0,0,0)});
    vecs.push_back('{1'b0, 7'b0110011, 3'd0, 1'b1, 1'b0, 1'b1, o(0,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,1,0)});
    // beq taken
    vecs.push_back('{1'b0, 7'b1100011, 3'd0, 1'b0, 1'b1, 1'b1, o(1,0,0,1,2'd2,2'd0,2'd2,3'd0,3'd2,0,0)});
    vecs.push_back('{1'b0, 7'b1100011, 3'd0, 1'b0, 1'b1, 1'b1, o(0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd2,0,0)});
    vecs.push_back('{1'b0, 7'b1100011, 3'd0, 1'b0, 1'b1, 1'b1, o(1,0,0,0,2'd0,2'd2,2'd0,3'd1,3'd2,0,0)});
    // bne with zero=1: not taken
    vecs.push_back('{1'b0, 7'b1100011, 3'd1, 1'b0, 1'b1, 1'b1, o(1,0,0,1,2'd2,2'd0,2'd2,3'd0,3'd2,0,0)});
    vecs.push_back('{1'b0, 7'b1100011, 3'd1, 1'b0, 1'b1, 1'b1, o(0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd2,0,0)});
    vecs.push_back('{1'b0, 7'b1100011, 3'd1, 1'b0, 1'b1, 1'b1, o(0,0,0,0,2'd0,2'd2,2'd0,3'd1,3'd2,0,0)});
    // unsupported opcode: pulse in DECODE, back to FETCH
    vecs.push_back('{1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b1, o(1,0,0,1,2'd2,2'd0,2'd2,3'd0,3'd0,0,0)});
    vecs.push_back('{1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b1, o(0,0,0,0,2'd0,2'd1,2'd1,3'd0,3'd0,0,1)});
    vecs.push_back('{1'b0, 7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, o(0,0,0,0,2'd2,2'd0,2'd2,3'd0,3'd0,0,0)});

    foreach (vecs[i]) begin
      reset = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].f3;
      funct7b5 = vecs[i].f7; zero = vecs[i].z; mem_ready = vecs[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d", i), act, vecs[i].exp);
      @(posedge clk); #1;
    end

    // ---------------- hand-written multi-cycle sequences ----------------
    run_instr("lw_stall", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3);
    run_instr("jal",      7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr("lui",      7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr("auipc",    7'b0010111, 3'd0, 1'b0, 1'b0, 1, 0);
    run_instr("addi_f7",  7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr("slt",      7'b0110011, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr("or",       7'b0110011, 3'd6, 1'b0, 1'b0, 0, 0);
    run_instr("andi",     7'b0010011, 3'd7, 1'b0, 1'b0, 0, 0);
    run_instr("blt",      7'b1100011, 3'd4, 1'b0, 1'b0, 0, 0);

    // reset for two cycles while a store waits in MEMWRITE
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    cyc("sw_abort.FETCH",    P_FETCH,    1'b1, 1'b0);
    cyc("sw_abort.DECODE",   P_DECODE,   1'b1, 1'b0);
    cyc("sw_abort.MEMADR",   P_MEMADR,   1'b1, 1'b0);
    cyc("sw_abort.MEMWRITE", P_MEMWRITE, 1'b0, 1'b0);
    cyc("sw_abort.rst1",     P_MEMWRITE, 1'b0, 1'b1);
    cyc("sw_abort.rst2",     P_FETCH,    1'b1, 1'b1);
    run_instr("sw_after_rst", 7'b0100011, 3'd2, 1'b0, 1'b0, 1, 2);

    // ---------------- randomized instruction stream ----------------
    for (int n = 0; n < 300; n++) begin
      logic [6:0] v;
      int sel = $urandom_range(0, 9);
      case (sel)
        0: v = 7'b0000011;
        1: v = 7'b0100011;
        2: v = 7'b0110011;
        3: v = 7'b0010011;
        4: v = 7'b1100011;
        5: v = 7'b1101111;
        6: v = 7'b0110111;
        7: v = 7'b0010111;
        default: v = 7'($urandom);
      endcase
      run_instr($sformatf("rnd%0d", n), v, 3'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
